// File: rtl/vending_machine_multi_if.sv
// Signal bundle between the coin/keypad front end, the vending controller and the
// dispenser/hopper drivers; master drives stimulus, slave is the controller.
interface vending_machine_multi_if #(
  parameter int CODE_W  = 3,
  parameter int VAL_W   = 8,
  parameter int STOCK_W = 4
);
  logic               start;
  logic               cancel;
  logic [CODE_W-1:0]  product_code;
  logic               coin_valid;
  logic [VAL_W-1:0]   coin_value;
  logic               online_payment;
  logic               cfg_we;
  logic [CODE_W-1:0]  cfg_idx;
  logic [VAL_W-1:0]   cfg_price;
  logic               restock_we;
  logic [CODE_W-1:0]  restock_idx;
  logic [STOCK_W-1:0] restock_qty;

  logic [2:0]         state;
  logic [VAL_W-1:0]   credit;
  logic [VAL_W-1:0]   product_price;
  logic               dispense_product;
  logic [CODE_W-1:0]  dispense_code;
  logic               change_valid;
  logic [VAL_W-1:0]   change_amount;
  logic               coin_reject;
  logic               select_error;
  logic [15:0]        sales_count;
  logic [23:0]        revenue;

  modport master (
    output start, cancel, product_code, coin_valid, coin_value, online_payment,
           cfg_we, cfg_idx, cfg_price, restock_we, restock_idx, restock_qty,
    input  state, credit, product_price, dispense_product, dispense_code,
           change_valid, change_amount, coin_reject, select_error,
           sales_count, revenue
  );

  modport slave (
    input  start, cancel, product_code, coin_valid, coin_value, online_payment,
           cfg_we, cfg_idx, cfg_price, restock_we, restock_idx, restock_qty,
    output state, credit, product_price, dispense_product, dispense_code,
           change_valid, change_amount, coin_reject, select_error,
           sales_count, revenue
  );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: price/stock tables, coin credit, timeout refund,
// paced change payout. Define VM_AUDIT_COUNTERS_EN to build the sales/revenue counters.
//
// state  | meaning
// IDLE   | waiting for start; coins rejected
// SELECT | one cycle: validate product_code, latch price
// PAY    | accumulating coins; cancel/timeout refund, paid or online -> vend
// VEND   | one cycle: dispense pulse, stock decrement, compute change
// CHANGE | pay remaining in CHANGE_UNIT pulses, then back to IDLE
module vending_machine_multi #(
  parameter int NUM_PRODUCTS   = 8,
  parameter int CODE_W         = 3,
  parameter int VAL_W          = 8,
  parameter int STOCK_W        = 4,
  parameter int CHANGE_UNIT    = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                   clk,
  input logic                   rst,
  vending_machine_multi_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PAY    = 3'd2,
    S_VEND   = 3'd3,
    S_CHANGE = 3'd4
  } state_t;

  localparam int                 TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [VAL_W-1:0]   UNIT     = VAL_W'(CHANGE_UNIT);

  state_t             state_q, state_d;
  logic [VAL_W-1:0]   credit_q, credit_d;
  logic [VAL_W-1:0]   price_q, price_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [VAL_W-1:0]   remaining_q, remaining_d;
  logic               online_q, online_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               coin_reject_q, coin_reject_d;
  logic               select_error_q, select_error_d;

  logic [VAL_W-1:0]   price_tbl [NUM_PRODUCTS];
  logic [STOCK_W-1:0] stock_tbl [NUM_PRODUCTS];
  logic [STOCK_W-1:0] stock_next [NUM_PRODUCTS];

  logic [VAL_W-1:0]   sel_price;
  logic [STOCK_W-1:0] sel_stock;
  logic [VAL_W:0]     coin_sum;
  logic               coin_acc;
  logic [VAL_W-1:0]   credit_next;
  logic [VAL_W-1:0]   chg_amt;

  // Codes with no matching slot fall through to price 0, which reads as unsellable.
  always_comb begin
    sel_price = '0;
    sel_stock = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (bus.product_code == CODE_W'(i)) begin
        sel_price = price_tbl[i];
        sel_stock = stock_tbl[i];
      end
    end
  end

  assign coin_sum    = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign coin_acc    = (state_q == S_PAY) && bus.coin_valid && !coin_sum[VAL_W];
  assign credit_next = coin_acc ? coin_sum[VAL_W-1:0] : credit_q;
  assign chg_amt     = (remaining_q > UNIT) ? UNIT : remaining_q;

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    price_d        = price_q;
    code_d         = code_q;
    remaining_d    = remaining_q;
    online_d       = online_q;
    timer_d        = timer_q;
    select_error_d = 1'b0;
    coin_reject_d  = bus.coin_valid && !coin_acc;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_SELECT;
      end

      S_SELECT: begin
        if (sel_price == '0 || sel_stock == '0) begin
          select_error_d = 1'b1;
          state_d        = S_IDLE;
        end else begin
          price_d  = sel_price;
          code_d   = bus.product_code;
          credit_d = '0;
          online_d = 1'b0;
          timer_d  = '0;
          state_d  = S_PAY;
        end
      end

      S_PAY: begin
        credit_d = credit_next;
        timer_d  = coin_acc ? '0 : timer_q + 1'b1;
        if (bus.cancel || timer_q == TMR_LAST) begin
          remaining_d = credit_next;
          credit_d    = '0;
          state_d     = S_CHANGE;
        end else if (credit_next >= price_q) begin
          state_d = S_VEND;
        end else if (bus.online_payment) begin
          online_d = 1'b1;
          state_d  = S_VEND;
        end
      end

      S_VEND: begin
        remaining_d = online_q ? credit_q : credit_q - price_q;
        credit_d    = '0;
        state_d     = S_CHANGE;
      end

      S_CHANGE: begin
        remaining_d = remaining_q - chg_amt;
        // Leave on the last pulse rather than spending an idle cycle at zero.
        if (remaining_q <= UNIT) begin
          price_d = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      price_q        <= '0;
      code_q         <= '0;
      remaining_q    <= '0;
      online_q       <= 1'b0;
      timer_q        <= '0;
      coin_reject_q  <= 1'b0;
      select_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      price_q        <= price_d;
      code_q         <= code_d;
      remaining_q    <= remaining_d;
      online_q       <= online_d;
      timer_q        <= timer_d;
      coin_reject_q  <= coin_reject_d;
      select_error_q <= select_error_d;
    end
  end

  // Restock and vend decrement merge into one saturating update per slot.
  always_comb begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      logic [STOCK_W:0] sum;
      sum = {1'b0, stock_tbl[i]};
      if (bus.restock_we && bus.restock_idx == CODE_W'(i))
        sum = sum + {1'b0, bus.restock_qty};
      if (state_q == S_VEND && code_q == CODE_W'(i) && sum != '0)
        sum = sum - 1'b1;
      stock_next[i] = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (rst) begin
        price_tbl[i] <= '0;
        stock_tbl[i] <= '0;
      end else begin
        if (bus.cfg_we && bus.cfg_idx == CODE_W'(i))
          price_tbl[i] <= bus.cfg_price;
        stock_tbl[i] <= stock_next[i];
      end
    end
  end

  assign bus.state            = state_q;
  assign bus.credit           = credit_q;
  assign bus.product_price    = price_q;
  assign bus.dispense_product = (state_q == S_VEND);
  assign bus.dispense_code    = (state_q == S_VEND) ? code_q : '0;
  assign bus.change_valid     = (state_q == S_CHANGE) && (remaining_q != '0);
  assign bus.change_amount    = bus.change_valid ? chg_amt : '0;
  assign bus.coin_reject      = coin_reject_q;
  assign bus.select_error     = select_error_q;

`ifdef VM_AUDIT_COUNTERS_EN
  logic [15:0] sales_q;
  logic [23:0] revenue_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sales_q   <= '0;
      revenue_q <= '0;
    end else if (state_q == S_VEND) begin
      sales_q   <= sales_q + 1'b1;
      revenue_q <= revenue_q + 24'(price_q);
    end
  end

  assign bus.sales_count = sales_q;
  assign bus.revenue     = revenue_q;
`else
  assign bus.sales_count = '0;
  assign bus.revenue     = '0;
`endif

endmodule
